// File: rtl/polylut_arbiter_if.sv
// Handshake bundle for polylut_arbiter: requester side, polylut engine side
// and response consumer side.
interface polylut_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned OUT_W  = 20
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_ready;
    logic [ADDR_W-1:0]      lut_addr;
    logic [OUT_W-1:0]       lut_m2;
    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [OUT_W-1:0]       rsp_data;
    logic                   rsp_ready;

    modport slave (
        input  req_valid, req_addr, lut_m2, rsp_ready,
        output req_ready, lut_addr, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_addr, lut_m2, rsp_ready,
        input  req_ready, lut_addr, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/polylut_arbiter.sv
// Round-robin, credit-guarded front end sharing one polylut engine among NREQ requesters.
// Optional POLYLUT_ARB_PERF_EN adds saturating perf_issued / perf_stall counters.
module polylut_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned OUT_W      = 20,
    parameter int unsigned LAT        = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    polylut_arbiter_if.slave bus
`ifdef POLYLUT_ARB_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [ADDR_W-1:0]       lut_addr_q, lut_addr_d;
    logic [LAT-1:0]          tag_v_q;
    logic [IDW-1:0]          tag_id_q [LAT];
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [CW-1:0]           count_q, count_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IDW+OUT_W-1:0]    mem_q [FIFO_DEPTH];

    logic [ADDR_W-1:0]       addr_arr [NREQ];
    logic [IDW-1:0]          cand;
    logic [IDW-1:0]          win_id;
    logic                    win_found;
    logic [CW:0]             credits;
    logic                    can_issue;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic [NREQ-1:0]         grant;

    always_comb begin
        for (int unsigned g = 0; g < NREQ; g++) begin
            addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
        end
    end

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr_q) + k) % NREQ);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign credits   = {1'b0, count_q} + {1'b0, inflight_q};
    assign can_issue = credits < (CW+1)'(FIFO_DEPTH);
    assign issue     = can_issue && win_found;
    assign push      = tag_v_q[LAT-1];
    assign pop       = (count_q != '0) && bus.rsp_ready;

    always_comb begin
        grant = '0;
        if (issue) begin
            grant[win_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        lut_addr_d = lut_addr_q;
        inflight_d = inflight_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (issue) begin
            ptr_d      = IDW'((32'(win_id) + 32'd1) % NREQ);
            lut_addr_d = addr_arr[win_id];
        end
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            lut_addr_q <= '0;
            tag_v_q    <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int unsigned s = 0; s < LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            lut_addr_q  <= lut_addr_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tag_v_q[0]  <= issue;
            tag_id_q[0] <= win_id;
            for (int unsigned s = 1; s < LAT; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    // Payload storage needs no reset: the head is only exposed while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tag_id_q[LAT-1], bus.lut_m2};
        end
    end

    assign bus.req_ready = grant;
    assign bus.lut_addr  = lut_addr_q;
    assign bus.rsp_valid = count_q != '0;
    assign bus.rsp_id    = mem_q[rd_ptr_q][IDW+OUT_W-1:OUT_W];
    assign bus.rsp_data  = mem_q[rd_ptr_q][OUT_W-1:0];

`ifdef POLYLUT_ARB_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (issue && (perf_issued_q != '1)) begin
                perf_issued_q <= perf_issued_q + 32'd1;
            end
            if ((|bus.req_valid) && !can_issue && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_polylut_arbiter.sv
// Self-checking bench for polylut_arbiter: grant table, directed corner sequences
// and a randomized run against a queue-based transaction model.
`timescale 1ns/1ps
module tb_polylut_arbiter;
    localparam int unsigned NREQ       = 4;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned OUT_W      = 20;
    localparam int unsigned LAT        = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    polylut_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

`ifdef POLYLUT_ARB_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    polylut_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef POLYLUT_ARB_PERF_EN
        , .perf_issued(perf_issued)
        , .perf_stall(perf_stall)
`endif
    );

    // Engine stand-in: M2 is registered once after lut_addr, giving LAT=2 to the push edge.
    function automatic logic [OUT_W-1:0] eng(input logic [ADDR_W-1:0] a);
        return (a[19:0] ^ a[63:44]) + a[39:20] + 20'h5A5A5;
    endfunction
    logic [OUT_W-1:0] eng_q = '0;
    always @(posedge clk) eng_q <= eng(bus.lut_addr);
    assign bus.lut_m2 = eng_q;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int unsigned i, input logic [ADDR_W-1:0] a);
        bus.req_addr[ADDR_W*i +: ADDR_W] = a;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
    endtask

    typedef struct packed {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] exp_ready;
    } vec_t;
    vec_t tbl [8];

    typedef struct {
        int unsigned       id;
        logic [ADDR_W-1:0] addr;
        int                due;
    } fl_t;
    typedef struct {
        int unsigned      id;
        logic [OUT_W-1:0] data;
    } rs_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] pool [100];
        logic [ADDR_W-1:0] a_single;
        logic [NREQ-1:0]   exp_ready;
        int unsigned       ids [$];
        fl_t               infl [$];
        rs_t               fifo [$];
        int                hs;
        int                w;
        int unsigned       ptr;
        int unsigned       pi;
        logic [ADDR_W-1:0] last_addr;

        tbl[0] = '{4'b0000, 4'b0000};
        tbl[1] = '{4'b0001, 4'b0001};
        tbl[2] = '{4'b0010, 4'b0010};
        tbl[3] = '{4'b0110, 4'b0010};
        tbl[4] = '{4'b1000, 4'b1000};
        tbl[5] = '{4'b1100, 4'b0100};
        tbl[6] = '{4'b1010, 4'b0010};
        tbl[7] = '{4'b1111, 4'b0001};

        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        #1;
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_lut_addr", 64'(bus.lut_addr), 64'd0);
        check("reset_req_ready", 64'(bus.req_ready), 64'd0);
        do_reset();

        // Grant table from the reset pointer with an empty pipeline.
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = tbl[i].valid;
            #1;
            check($sformatf("table_ready[%0d]", i), 64'(bus.req_ready), 64'(tbl[i].exp_ready));
            bus.req_valid = '0;
            tick();
        end

        // Single request from requester 2.
        do_reset();
        a_single = 64'h1234567890ABCDEF;
        bus.rsp_ready = 1'b1;
        set_addr(2, a_single);
        bus.req_valid = 4'b0100;
        #1;
        check("single_ready", 64'(bus.req_ready), 64'(4'b0100));
        tick();
        bus.req_valid = '0;
        #1;
        check("single_lut_addr", 64'(bus.lut_addr), a_single);
        check("single_ready_off", 64'(bus.req_ready), 64'd0);
        check("single_early1", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("single_early2", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("single_rsp_id", 64'(bus.rsp_id), 64'd2);
        check("single_rsp_data", 64'(bus.rsp_data), 64'(eng(a_single)));
        tick();
        check("single_popped", 64'(bus.rsp_valid), 64'd0);

        // Fairness: all requesting, responses drained continuously.
        do_reset();
        for (int unsigned i = 0; i < NREQ; i++) set_addr(i, 64'hF00D_0000_0000_0000 + 64'(i * 7 + 3));
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        ids.delete();
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("fair_grant[%0d]", k), 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            if (bus.rsp_valid) ids.push_back(int'(bus.rsp_id));
            tick();
        end
        bus.req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bus.rsp_valid) ids.push_back(int'(bus.rsp_id));
            tick();
        end
        check("fair_rsp_count", 64'(ids.size()), 64'd8);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("fair_rsp_id[%0d]", j), (j < ids.size()) ? 64'(ids[j]) : 64'hFF, 64'(j % 4));
        end

        // Back-pressure: no pops, credits run out after FIFO_DEPTH handshakes.
        do_reset();
        for (int unsigned i = 0; i < NREQ; i++) set_addr(i, 64'hBEEF_0000_0000_0000 + 64'(i + 1));
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1111;
        hs = 0;
        for (int k = 0; k < 14; k++) begin
            #1;
            if (|(bus.req_ready & bus.req_valid)) hs++;
            tick();
        end
        check("bp_handshakes", 64'(hs), 64'd4);
        check("bp_ready_low", 64'(bus.req_ready), 64'd0);
        check("bp_head_id", 64'(bus.rsp_id), 64'd0);
        check("bp_head_data", 64'(bus.rsp_data), 64'(eng(64'hBEEF_0000_0000_0001)));
`ifdef POLYLUT_ARB_PERF_EN
        check("perf_issued", 64'(perf_issued), 64'd4);
        check("perf_stall", 64'(perf_stall), 64'd10);
`endif
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_no_grant_pop_cycle", 64'(bus.req_ready), 64'd0);
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        check("bp_grant_after_pop", 64'(bus.req_ready), 64'(4'b0001));
        hs = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (|(bus.req_ready & bus.req_valid)) hs++;
            tick();
        end
        check("bp_one_more_grant", 64'(hs), 64'd1);

        // Mid-flight asynchronous reset with two issues outstanding.
        do_reset();
        for (int unsigned i = 0; i < NREQ; i++) set_addr(i, 64'h0101_0101_0101_0101 * 64'(i + 1));
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        tick();
        tick();
        bus.req_valid = '0;
        #1;
        check("mid_lut_addr_before", 64'(bus.lut_addr), 64'h0202_0202_0202_0202);
        #2 rst = 1'b0;
        #1;
        check("mid_rsp_valid_async", 64'(bus.rsp_valid), 64'd0);
        check("mid_lut_addr_async", 64'(bus.lut_addr), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("mid_no_stale[%0d]", k), 64'(bus.rsp_valid), 64'd0);
            tick();
        end
        bus.req_valid = 4'b1111;
        #1;
        check("mid_first_grant", 64'(bus.req_ready), 64'(4'b0001));
        bus.req_valid = '0;
        tick();

        // Randomized run against a transaction-level model.
        do_reset();
        pool[0] = 64'h0;
        pool[1] = 64'h1;
        pool[2] = 64'h2;
        pool[3] = '1;
        for (int i = 4; i < 100; i++) pool[i] = {$urandom(), $urandom()};
        infl.delete();
        fifo.delete();
        ptr = 0;
        pi = 0;
        last_addr = '0;
        for (int cyc = 0; cyc < 430; cyc++) begin
            if (cyc < 150) begin
                bus.req_valid = 4'b1111;
                bus.rsp_ready = 1'b1;
            end else if (cyc < 400) begin
                bus.req_valid = 4'($urandom());
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.req_valid = '0;
                bus.rsp_ready = 1'b1;
            end
            for (int unsigned i = 0; i < NREQ; i++) set_addr(i, pool[(pi + i) % 100]);
            #1;
            exp_ready = '0;
            w = -1;
            if (fifo.size() + infl.size() < FIFO_DEPTH) begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    if (w < 0 && bus.req_valid[(ptr + k) % NREQ]) w = int'((ptr + k) % NREQ);
                end
            end
            if (w >= 0) exp_ready[w] = 1'b1;
            check("rand_req_ready", 64'(bus.req_ready), 64'(exp_ready));
            check("rand_rsp_valid", 64'(bus.rsp_valid), 64'(fifo.size() > 0));
            check("rand_lut_addr", 64'(bus.lut_addr), last_addr);
            if (fifo.size() > 0) begin
                check("rand_rsp_id", 64'(bus.rsp_id), 64'(fifo[0].id));
                check("rand_rsp_data", 64'(bus.rsp_data), 64'(fifo[0].data));
            end
            if (fifo.size() > 0 && bus.rsp_ready) void'(fifo.pop_front());
            if (infl.size() > 0 && infl[0].due == cyc) begin
                fifo.push_back('{infl[0].id, eng(infl[0].addr)});
                void'(infl.pop_front());
            end
            if (w >= 0) begin
                last_addr = pool[(pi + int'(w)) % 100];
                infl.push_back('{int'(w), last_addr, cyc + int'(LAT)});
                ptr = (int'(w) + 1) % NREQ;
                pi = (pi + 1) % 100;
            end
            tick();
        end
        check("rand_drained", 64'(bus.rsp_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/polylut_arbiter.md
# polylut_arbiter

Round-robin front end that shares one `polylut` inference engine among NREQ requesters. It accepts 64-bit input vectors over valid/ready, issues at most one per cycle to the engine's `address` input, and tracks each issue through the engine's fixed pipeline latency with a tag shift register. The 20-bit `M2` results land in a credit-guarded response FIFO and are returned with the originating requester ID. It sits between the feature-extraction stage and the `polylut` layer.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `ADDR_W`, 64: engine input width, equal to `polylut` `address`
- `OUT_W`, 20: engine output width, equal to `polylut` `M2`
- `LAT`, 2: cycles from `lut_addr` change to valid `lut_m2`, 1..8
- `FIFO_DEPTH`, 4: response FIFO entries, power of two, ≥ LAT+1
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  request valid, one bit per requester
- `req_addr`  in  NREQ*ADDR_W  request vectors; requester i at bits [i*ADDR_W +: ADDR_W]
- `req_ready`  out  NREQ  one-hot grant/accept
- `lut_addr`  out  ADDR_W  registered drive to `polylut.address`
- `lut_m2`  in  OUT_W  from `polylut.M2`
- `rsp_valid`  out  1  FIFO head valid
- `rsp_id`  out  clog2(NREQ)  requester index of head entry
- `rsp_data`  out  OUT_W  `M2` result of head entry
- `rsp_ready`  in  1  consumer accepts head

## Operation
- Credit check: `can_issue = (fifo_count + inflight) < FIFO_DEPTH`, both counts registered. A pop this cycle frees its credit next cycle.
- Arbitration: round-robin pointer `ptr`, reset 0. The winner is the first i in ptr, ptr+1, … (mod NREQ) with `req_valid[i]`.
- `req_ready` is one-hot at the winner when `can_issue`, otherwise all zero. It is combinational from `req_valid`, `ptr` and the counts. Requesters must not make `req_valid` depend on `req_ready`.
- Handshake: `req_valid[i] && req_ready[i]`. The next cycle `lut_addr` takes `req_addr[i]`, `ptr` becomes (i+1) mod NREQ, and a tag {1, i} enters stage 0 of an LAT-deep tag pipeline.
- With no issue, `lut_addr` holds its value, `ptr` is unchanged, and a {0, x} bubble enters.
- At the last tag stage, a valid tag pushes {id, `lut_m2`} into the FIFO.
- `inflight` counts valid tags in the pipeline. It increments on issue, decrements on push, and is unchanged when both happen.
- FIFO is first-word fall-through. `rsp_*` reflect the head, and a pop happens on `rsp_valid && rsp_ready`. Push and pop in the same cycle are both performed; push into a full FIFO cannot occur because of the credit check.
- Reset (asynchronous assert, at any time including mid-flight):
  - `lut_addr`=0, `ptr`=0, all tags invalid, `inflight`=0, FIFO empty, `rsp_valid`=0.
  - In-flight results are discarded.

## Timing
- Issue rate: one per cycle while credits remain.
- Latency from handshake edge to `rsp_valid` with an empty FIFO: 1+LAT cycles.
- Steady-state throughput is 1/cycle when `rsp_ready` is held high and FIFO_DEPTH ≥ LAT+2. At exactly LAT+1 the freed-credit delay allows LAT+1 issues per LAT+2 cycles.
- `rsp_id`/`rsp_data` are stable while `rsp_valid && !rsp_ready`.
- `req_ready` goes low the same cycle credits are exhausted.

## Configuration
- `POLYLUT_ARB_PERF_EN` defined adds two outputs, both reset to 0, both saturating at all-ones:
  - `perf_issued` (32): count of handshakes.
  - `perf_stall` (32): count of cycles with any `req_valid` high but `can_issue` low.
- Without the macro these ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- Single request: req 2 holds `req_addr`=64'h1234567890ABCDEF, `rsp_ready`=1, LAT=2.
  - `req_ready`=4'b0100 for one cycle, then `lut_addr` equals that value.
  - 3 cycles after the handshake, `rsp_valid`=1, `rsp_id`=2, `rsp_data` equals the engine `M2`.
- Fairness: all four `req_valid` held high. Grant order is 0,1,2,3,0,…; over 8 issues each requester gets 2 and `rsp_id` follows the same order.
- Back-pressure: `rsp_ready`=0, all requesting, FIFO_DEPTH=4.
  - Exactly 4 handshakes occur, then `req_ready`=0.
  - Raising `rsp_ready` for one pop allows exactly one further grant, made the cycle after the pop.
- Simultaneous push/pop: full stream with `rsp_ready`=1. `fifo_count` stays constant and no result is lost or duplicated (scoreboard of 100 random vectors including 64'h0, 64'h1, 64'h2, all-ones).
- Mid-flight reset: assert `rst`=0 with 2 in flight.
  - `rsp_valid` and `lut_addr` are 0 immediately, without waiting for a clock edge.
  - After release, the next grant goes to requester 0 and no stale response appears.
- Perf (`POLYLUT_ARB_PERF_EN`): the back-pressure scenario held for 10 stalled cycles gives `perf_issued`=4 and `perf_stall`=10.
